// File: rtl/alu_big_module_pkg.sv
// alu_big_module_pkg: alu_op, funct and forward-select codes plus the internal ALU-control enum
package alu_big_module_pkg;
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_FUNCT = 3'b010, OP_AND = 3'b011;
  localparam logic [2:0] OP_OR = 3'b100, OP_SLT = 3'b101, OP_XOR = 3'b110, OP_ADD_ALT = 3'b111;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03;
  localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B;
  localparam logic [1:0] FWD_RF = 2'b00, FWD_MEM_WB = 2'b01, FWD_EX_MEM = 2'b10;
  typedef enum logic [3:0] {
    CTL_ZERO, CTL_ADD, CTL_ADDU, CTL_SUB, CTL_SUBU, CTL_AND, CTL_OR,
    CTL_XOR, CTL_NOR, CTL_SLT, CTL_SLTU, CTL_SLL, CTL_SRL, CTL_SRA
  } alu_ctl_e;
endpackage

// File: rtl/alu_big_module_alu_control.sv
// alu_control: maps alu_op and funct to alu_ctl_e; funct shifts decode only when ALU_SHIFT_EN is defined
module alu_control
  import alu_big_module_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] ctl
);
  alu_ctl_e f_ctl, op_ctl;
  always_comb begin
    case (funct)
      F_ADD:   f_ctl = CTL_ADD;
      F_ADDU:  f_ctl = CTL_ADDU;
      F_SUB:   f_ctl = CTL_SUB;
      F_SUBU:  f_ctl = CTL_SUBU;
      F_AND:   f_ctl = CTL_AND;
      F_OR:    f_ctl = CTL_OR;
      F_XOR:   f_ctl = CTL_XOR;
      F_NOR:   f_ctl = CTL_NOR;
      F_SLT:   f_ctl = CTL_SLT;
      F_SLTU:  f_ctl = CTL_SLTU;
`ifdef ALU_SHIFT_EN
      F_SLL:   f_ctl = CTL_SLL;
      F_SRL:   f_ctl = CTL_SRL;
      F_SRA:   f_ctl = CTL_SRA;
`endif
      default: f_ctl = CTL_ZERO;
    endcase
  end
  always_comb begin
    case (alu_op)
      OP_SUB:   op_ctl = CTL_SUB;
      OP_FUNCT: op_ctl = f_ctl;
      OP_AND:   op_ctl = CTL_AND;
      OP_OR:    op_ctl = CTL_OR;
      OP_SLT:   op_ctl = CTL_SLT;
      OP_XOR:   op_ctl = CTL_XOR;
      default:  op_ctl = CTL_ADD;
    endcase
  end
  assign ctl = op_ctl;
endmodule

// File: rtl/alu_big_module.sv
// alu_big_module: forwarding muxes, combinational ALU and registered zero/overflow flags (shifts via ALU_SHIFT_EN)
module alu_big_module
  import alu_big_module_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  ForwardA,
  input  logic [1:0]  ForwardB,
  input  logic [31:0] read_data_1,
  input  logic [31:0] read_data_2,
  input  logic [31:0] EX_MEM_alu_result,
  input  logic [31:0] MEM_WB_read_data,
  input  logic [31:0] ins_15_0,
  input  logic [2:0]  alu_op,
  input  logic        alu_src,
  output logic [31:0] alu_result,
  output logic [31:0] write_data,
  output logic        zero,
  output logic        zero_q,
  output logic        ovf_q
);
  logic [31:0] a, b_fwd, b, sum, diff;
  logic [3:0]  ctl_raw;
  logic [4:0]  shamt;
  alu_ctl_e    ctl;
  logic        ovf;
  assign a = ForwardA == FWD_EX_MEM ? EX_MEM_alu_result : ForwardA == FWD_MEM_WB ? MEM_WB_read_data : read_data_1;
  assign b_fwd = ForwardB == FWD_EX_MEM ? EX_MEM_alu_result : ForwardB == FWD_MEM_WB ? MEM_WB_read_data : read_data_2;
  assign b = alu_src ? ins_15_0 : b_fwd;
  assign write_data = b_fwd;
  assign shamt = ins_15_0[10:6];
  assign sum = a + b;
  assign diff = a - b;
  alu_control u_alu_control (
    .alu_op (alu_op),
    .funct  (ins_15_0[5:0]),
    .ctl    (ctl_raw)
  );
  assign ctl = alu_ctl_e'(ctl_raw);
  always_comb begin
    case (ctl)
      CTL_ADD, CTL_ADDU: alu_result = sum;
      CTL_SUB, CTL_SUBU: alu_result = diff;
      CTL_AND:  alu_result = a & b;
      CTL_OR:   alu_result = a | b;
      CTL_XOR:  alu_result = a ^ b;
      CTL_NOR:  alu_result = ~(a | b);
      CTL_SLT:  alu_result = {31'b0, $signed(a) < $signed(b)};
      CTL_SLTU: alu_result = {31'b0, a < b};
      CTL_SLL:  alu_result = b << shamt;
      CTL_SRL:  alu_result = b >> shamt;
      CTL_SRA:  alu_result = $signed(b) >>> shamt;
      default:  alu_result = '0;
    endcase
  end
  // signed overflow: operands agree in sign (add) or differ (sub) and the result sign flips away from a
  assign ovf = ctl == CTL_ADD ? (a[31] == b[31] && sum[31] != a[31]) :
               ctl == CTL_SUB ? (a[31] != b[31] && diff[31] != a[31]) : 1'b0;
  assign zero = alu_result == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero;
      ovf_q  <= ovf;
    end
  end
endmodule

// File: tb/tb_alu_big_module.sv
// tb_alu_big_module: directed vectors checked against an arithmetic reference model every cycle
module tb_alu_big_module;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  fa = '0, fb = '0;
  logic [31:0] r1 = '0, r2 = '0, ex = '0, wb = '0, imm = '0;
  logic [2:0]  op = '0;
  logic        src = 1'b0;
  logic [31:0] alu_result, write_data;
  logic        zero, zero_q, ovf_q;
  int          n_vec = 0, n_err = 0;
  logic        ez = 1'b0, eo = 1'b0;
  logic [32:0] m;
  logic [31:0] m_wd;

  alu_big_module dut (
    .clk(clk), .rst_n(rst_n), .ForwardA(fa), .ForwardB(fb),
    .read_data_1(r1), .read_data_2(r2), .EX_MEM_alu_result(ex), .MEM_WB_read_data(wb),
    .ins_15_0(imm), .alu_op(op), .alu_src(src),
    .alu_result(alu_result), .write_data(write_data), .zero(zero), .zero_q(zero_q), .ovf_q(ovf_q)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf, input logic [31:0] exv, input logic [31:0] wbv);
    case (sel)
      2'b10:   return exv;
      2'b01:   return wbv;
      default: return rf;
    endcase
  endfunction

  // returns {overflow, result}; alu_op classes are expressed as their funct equivalents
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ins, input logic [2:0] o);
    longint sa, sb, s;
    int f;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    f = (o == 3'd2) ? int'(ins[5:0]) : (o == 3'd1) ? 'h22 : (o == 3'd3) ? 'h24 :
        (o == 3'd4) ? 'h25 : (o == 3'd5) ? 'h2A : (o == 3'd6) ? 'h26 : 'h20;
    case (f)
      'h20: begin s = sa + sb; return {s > 64'sd2147483647 || s < -64'sd2147483648, 32'(s)}; end
      'h22: begin s = sa - sb; return {s > 64'sd2147483647 || s < -64'sd2147483648, 32'(s)}; end
      'h21: return {1'b0, a + b};
      'h23: return {1'b0, a - b};
      'h24: return {1'b0, a & b};
      'h25: return {1'b0, a | b};
      'h26: return {1'b0, a ^ b};
      'h27: return {1'b0, ~(a | b)};
      'h2A: return {1'b0, (sa < sb) ? 32'd1 : 32'd0};
      'h2B: return {1'b0, (a < b) ? 32'd1 : 32'd0};
`ifdef ALU_SHIFT_EN
      'h00: return {1'b0, b * (32'd1 << ins[10:6])};
      'h02: return {1'b0, 32'(longint'(b) / (longint'(1) << ins[10:6]))};
      'h03: return {1'b0, 32'(sb >>> ins[10:6])};
`endif
      default: return 33'd0;
    endcase
  endfunction

  assign m_wd = pick(fb, r2, ex, wb);
  assign m = model(pick(fa, r1, ex, wb), src ? imm : m_wd, imm, op);

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ez <= 1'b0;
      eo <= 1'b0;
    end else begin
      ez <= (m[31:0] == 32'd0);
      eo <= m[32];
    end

  always @(negedge clk) begin
    n_vec++;
    if (alu_result !== m[31:0] || write_data !== m_wd || zero !== (m[31:0] == 32'd0) || zero_q !== ez || ovf_q !== eo) begin
      n_err++;
      $display("FAIL model t=%0t: res=%h wd=%h z=%b zq=%b oq=%b expected res=%h wd=%h z=%b zq=%b oq=%b",
               $time, alu_result, write_data, zero, zero_q, ovf_q, m[31:0], m_wd, m[31:0] == 32'd0, ez, eo);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] fa_i, input logic [1:0] fb_i, input logic [31:0] r1_i, input logic [31:0] r2_i,
                       input logic [31:0] ex_i, input logic [31:0] wb_i, input logic [31:0] imm_i, input logic [2:0] op_i, input logic src_i);
    @(posedge clk);
    #2;
    fa = fa_i; fb = fb_i; r1 = r1_i; r2 = r2_i; ex = ex_i; wb = wb_i; imm = imm_i; op = op_i; src = src_i;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    check("reset zero_q", zero_q, 0);
    check("reset ovf_q", ovf_q, 0);
    check("reset comb zero", zero, 1);
    #2 rst_n = 1'b1;
    drive(2'b00, 2'b00, 10, 20, 0, 0, 32'h20, 3'b010, 0);
    check("funct add", alu_result, 30);
    check("funct add wd", write_data, 20);
    drive(2'b00, 2'b00, 30, 5, 0, 0, 32'h22, 3'b010, 0);
    check("funct sub", alu_result, 25);
    drive(2'b00, 2'b00, 100, 999, 0, 0, 4, 3'b000, 1);
    check("imm add", alu_result, 104);
    check("imm add wd", write_data, 999);
    drive(2'b00, 2'b00, 10, 10, 0, 0, 0, 3'b001, 0);
    check("sub zero", alu_result, 0);
    check("sub zero flag", zero, 1);
    @(negedge clk);
    check("zero_q", zero_q, 1);
    drive(2'b10, 2'b00, 10, 20, 50, 0, 32'h20, 3'b010, 0);
    check("fwd ex_mem", alu_result, 70);
    drive(2'b00, 2'b01, 10, 20, 50, 99, 32'h20, 3'b010, 0);
    check("fwd mem_wb", alu_result, 109);
    check("fwd mem_wb wd", write_data, 99);
    drive(2'b00, 2'b00, 32'h7FFF_FFFF, 1, 0, 0, 0, 3'b000, 0);
    check("add ovf res", alu_result, 32'h8000_0000);
    @(negedge clk);
    check("ovf_q", ovf_q, 1);
    #2 rst_n = 1'b0;
    #1 check("async reset ovf_q", ovf_q, 0);
    check("reset keeps comb", alu_result, 32'h8000_0000);
    @(negedge clk);
    #1 rst_n = 1'b1;
    drive(2'b00, 2'b00, 0, 1, 0, 0, 32'h100, 3'b010, 0);
`ifdef ALU_SHIFT_EN
    check("sll", alu_result, 16);
`else
    check("sll off", alu_result, 0);
`endif
    drive(2'b00, 2'b00, 32'hFFFF_FFFF, 1, 0, 0, 32'h2A, 3'b010, 0);
    check("slt", alu_result, 1);
    drive(2'b00, 2'b00, 32'hFFFF_FFFF, 1, 0, 0, 32'h2B, 3'b010, 0);
    check("sltu", alu_result, 0);
    drive(2'b00, 2'b00, 32'h8000_0000, 1, 0, 0, 0, 3'b001, 0);
    check("sub ovf res", alu_result, 32'h7FFF_FFFF);
    @(negedge clk);
    check("sub ovf_q", ovf_q, 1);
    drive(2'b00, 2'b00, 32'h7FFF_FFFF, 1, 0, 0, 32'h21, 3'b010, 0);
    check("addu res", alu_result, 32'h8000_0000);
    @(negedge clk);
    check("addu no ovf", ovf_q, 0);
    drive(2'b00, 2'b00, 0, 0, 0, 0, 32'h27, 3'b010, 0);
    check("nor", alu_result, 32'hFFFF_FFFF);
    drive(2'b00, 2'b00, 0, 1, 0, 0, 32'h23, 3'b010, 0);
    check("subu wrap", alu_result, 32'hFFFF_FFFF);
    drive(2'b00, 2'b00, 5, 7, 0, 0, 32'h3F, 3'b010, 0);
    check("bad funct", alu_result, 0);
    drive(2'b11, 2'b11, 1, 2, 40, 50, 0, 3'b111, 0);
    check("fwd 11 add", alu_result, 3);
    drive(2'b00, 2'b00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 0, 3'b011, 0);
    check("and", alu_result, 32'h00F0_00F0);
    drive(2'b00, 2'b00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 0, 3'b100, 0);
    check("or", alu_result, 32'hFFF0_FFF0);
    drive(2'b00, 2'b00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 0, 3'b110, 0);
    check("xor", alu_result, 32'hFF00_FF00);
    drive(2'b00, 2'b00, 32'hFFFF_FFFB, 3, 0, 0, 0, 3'b101, 0);
    check("op slt", alu_result, 1);
    drive(2'b00, 2'b00, 5, 0, 0, 0, 32'h20, 3'b010, 1);
    check("funct with imm", alu_result, 32'h25);
    drive(2'b00, 2'b00, 0, 32'h80, 0, 0, 32'h102, 3'b010, 0);
`ifdef ALU_SHIFT_EN
    check("srl", alu_result, 8);
`else
    check("srl off", alu_result, 0);
`endif
    drive(2'b00, 2'b00, 0, 32'h8000_0000, 0, 0, 32'h103, 3'b010, 0);
`ifdef ALU_SHIFT_EN
    check("sra", alu_result, 32'hF800_0000);
`else
    check("sra off", alu_result, 0);
`endif
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
